// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared constants for the multi-cycle MIPS control sequencer.
//                Holds the opcode values, the 4-bit state encoding, and the
//                aluSrcB / aluOp / pcSource selector codes. Also provides a
//                helper that identifies the states that retire an instruction.
//  Revision    : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Sequencer states; the encoding is visible on the debug state port.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic is_retiring(input state_t s);
    case (s)
      S_MEMWB, S_MEMWR, S_RWB, S_ADDI_WB, S_BRANCH, S_JUMP: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Control bus between the multi-cycle sequencer and the MIPS
//                datapath / shared memory.
//                master : sequencer side (takes opCode, zeroFlag, mem_ready;
//                         drives all control strobes, state, illegal, count)
//                slave  : datapath side (mirror image of master)
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  // datapath -> sequencer
  logic [5:0]       opCode;
  logic             zeroFlag;
  logic             mem_ready;
  // sequencer -> datapath
  logic             pcWrite;
  logic             pcWriteCond;
  logic             iorD;
  logic             memRead;
  logic             memWrite;
  logic             irWrite;
  logic             memtoReg;
  logic             regDst;
  logic             regWrite;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       aluOp;
  logic [1:0]       pcSource;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opCode, zeroFlag, mem_ready,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           state, illegal, instr_count
  );

  modport slave (
    output opCode, zeroFlag, mem_ready,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           state, illegal, instr_count
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle MIPS control sequencer. Steps the datapath one
//                phase per clock, stalls on the shared memory via mem_ready,
//                counts retired instructions and flags unknown opcodes.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-low reset (0 = reset)
//                bus    - control bus, master side (see multicycle_control_if)
//  Parameters  : CNT_W  - width of the retired-instruction counter
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  multicycle_control_if.master  bus
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_set_illegal;
  logic             w_retire;

  // --------------------------------------------------------------------------
  // State, sticky illegal flag and retire counter. Reset is asynchronous so
  // an instruction in flight is abandoned before any further strobe issues.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + C_ONE;
      end
    end
  end

  // MEMWR only leaves on mem_ready, so retirement is tied to the actual
  // transition into FETCH rather than to simply being in a retiring state.
  assign w_retire = is_retiring(r_state) && (w_next == S_FETCH);

  // --------------------------------------------------------------------------
  // Next-state and control decode. Outputs depend on state only, except the
  // FETCH strobes irWrite/pcWrite which wait for the memory to deliver.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next          = r_state;
    w_set_illegal   = 1'b0;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.memtoReg    = 1'b0;
    bus.regDst      = 1'b0;
    bus.regWrite    = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = SRCB_RT;
    bus.aluOp       = ALUOP_ADD;
    bus.pcSource    = PCSRC_ALU;

    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        bus.memRead  = 1'b1;
        bus.aluSrcB  = SRCB_FOUR;
        if (bus.mem_ready) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          w_next      = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is computed speculatively while decoding.
        bus.aluSrcB = SRCB_IMM_SH2;
        case (bus.opCode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next        = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        // IR still holds the instruction, so opCode separates lw from sw.
        w_next = (bus.opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memtoReg = 1'b1;
        w_next       = S_FETCH;
      end

      S_MEMWR: begin
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_FETCH;
        end
      end

      S_EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluOp   = ALUOP_FUNCT;
        w_next      = S_RWB;
      end

      S_RWB: begin
        bus.regWrite = 1'b1;
        bus.regDst   = 1'b1;
        w_next       = S_FETCH;
      end

      S_ADDI_EX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        w_next      = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        bus.regWrite = 1'b1;
        w_next       = S_FETCH;
      end

      S_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = ALUOP_SUB;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = PCSRC_ALUOUT;
        w_next          = S_FETCH;
      end

      S_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = PCSRC_JUMP;
        w_next       = S_FETCH;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.state       = r_state;
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Scoreboard bench for multicycle_control. The driver expands
//                each instruction into its per-cycle step list, pushes the
//                expected control word and status for every cycle, and a
//                negedge monitor pops and compares. Counter width is 4 so
//                the retire counter wrap is reached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  localparam int CNT_W = 4;

  // Step codes, numbered as the debug state encoding.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3,
                 PH_MEMRD = 4, PH_MEMWB = 5, PH_MEMWR = 6, PH_EXEC = 7,
                 PH_RWB = 8, PH_ADDI_EX = 9, PH_ADDI_WB = 10,
                 PH_BRANCH = 11, PH_JUMP = 12;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic [3:0] state;
  } cw_t;

  typedef struct packed {
    cw_t              cw;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   m_cnt    = 0;   // model: retired instructions
  logic m_ill    = 1'b0; // model: illegal seen since reset

  // Expected control word for one step, straight from the control table.
  function automatic cw_t cw(input int ph, input logic rdy);
    cw_t c;
    c = '0;
    c.state = ph[3:0];
    case (ph)
      PH_FETCH:   begin c.memRead = 1'b1; c.aluSrcB = 2'b01;
                        c.irWrite = rdy;  c.pcWrite = rdy; end
      PH_DECODE:  begin c.aluSrcB = 2'b11; end
      PH_MEMADR:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      PH_MEMRD:   begin c.memRead = 1'b1; c.iorD = 1'b1; end
      PH_MEMWB:   begin c.regWrite = 1'b1; c.memtoReg = 1'b1; end
      PH_MEMWR:   begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      PH_EXEC:    begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      PH_RWB:     begin c.regWrite = 1'b1; c.regDst = 1'b1; end
      PH_ADDI_EX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      PH_ADDI_WB: begin c.regWrite = 1'b1; end
      PH_BRANCH:  begin c.aluSrcA = 1'b1; c.aluOp = 2'b01;
                        c.pcWriteCond = 1'b1; c.pcSource = 2'b01; end
      PH_JUMP:    begin c.pcWrite = 1'b1; c.pcSource = 2'b10; end
      default:    ;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus plus the expectation for that cycle.
  task automatic drive(input logic rst, input logic rdy, input logic [5:0] op,
                       input logic zf, input cw_t exp);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = rdy;
    bus.opCode    = op;
    bus.zeroFlag  = zf;
    if (!rst) begin
      m_cnt = 0;
      m_ill = 1'b0;
    end
    e.cw  = exp;
    e.ill = m_ill;
    e.cnt = m_cnt[CNT_W-1:0];
    sb.push_back(e);
  endtask

  task automatic step(input int ph, input logic [5:0] op, input logic zf);
    drive(1'b1, rb(), op, zf, cw(ph, 1'b0));
  endtask

  task automatic mem_wait(input int ph, input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) drive(1'b1, 1'b0, op, rb(), cw(ph, 1'b0));
    drive(1'b1, 1'b1, op, rb(), cw(ph, 1'b1));
  endtask

  // Expand one instruction. abort asserts reset during the lw memory read.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input bit abort);
    for (int i = 0; i < fw; i++)
      drive(1'b1, 1'b0, 6'($urandom), rb(), cw(PH_FETCH, 1'b0));
    drive(1'b1, 1'b1, 6'($urandom), rb(), cw(PH_FETCH, 1'b1));
    step(PH_DECODE, op, rb());
    case (op)
      6'b100011: begin
        step(PH_MEMADR, op, rb());
        if (abort) begin
          drive(1'b1, 1'b0, op, rb(), cw(PH_MEMRD, 1'b0));
          drive(1'b0, rb(), op, rb(), cw(PH_IDLE, 1'b0));
          drive(1'b0, rb(), op, rb(), cw(PH_IDLE, 1'b0));
          drive(1'b1, rb(), op, rb(), cw(PH_IDLE, 1'b0));
          return;
        end
        mem_wait(PH_MEMRD, op, mw);
        step(PH_MEMWB, op, rb());
      end
      6'b101011: begin
        step(PH_MEMADR, op, rb());
        mem_wait(PH_MEMWR, op, mw);
      end
      6'b000000: begin step(PH_EXEC, op, rb()); step(PH_RWB, op, rb()); end
      6'b000100: step(PH_BRANCH, op, 1'b1);
      6'b001000: begin step(PH_ADDI_EX, op, rb()); step(PH_ADDI_WB, op, rb()); end
      6'b000010: step(PH_JUMP, op, rb());
      default: begin
        m_ill = 1'b1;
        return;
      end
    endcase
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  // Monitor: compares every cycle that has a pending expectation.
  always @(negedge clk) begin
    exp_t e;
    cw_t  got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite,
             bus.irWrite, bus.memtoReg, bus.regDst, bus.regWrite, bus.aluSrcA,
             bus.aluSrcB, bus.aluOp, bus.pcSource, bus.state};
      n_checks++;
      if (got === e.cw) n_pass++;
      else $display("FAIL ctrl cyc=%0d got=%05h expected=%05h (state got %0d expected %0d)",
                    cyc, got, e.cw, got.state, e.cw.state);
      n_checks++;
      if (bus.illegal === e.ill && bus.instr_count === e.cnt) n_pass++;
      else $display("FAIL status cyc=%0d got illegal=%b count=%0d expected illegal=%b count=%0d",
                    cyc, bus.illegal, bus.instr_count, e.ill, e.cnt);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    bus.opCode    = 6'd0;
    bus.zeroFlag  = 1'b0;
    bus.mem_ready = 1'b0;
    #2 reset = 1'b0;

    // Reset held for 3 clocks, then one IDLE cycle after release.
    repeat (3) drive(1'b0, 1'b0, 6'd0, 1'b0, cw(PH_IDLE, 1'b0));
    drive(1'b1, 1'b0, 6'd0, 1'b0, cw(PH_IDLE, 1'b0));

    run_instr(6'b100011, 0, 0, 1'b0);          // lw, no waits
    run_instr(6'b101011, 0, 3, 1'b0);          // sw, 3 wait cycles
    run_instr(6'b000100, 1, 0, 1'b0);          // beq
    run_instr(6'b000010, 0, 0, 1'b0);          // j
    run_instr(6'b111111, 2, 0, 1'b0);          // illegal
    repeat (16) run_instr(6'b000000, 0, 0, 1'b0); // counter wrap
    run_instr(6'b001000, 2, 0, 1'b0);          // addi
    run_instr(6'b100011, 0, 0, 1'b1);          // lw aborted by reset

    repeat (40) begin
      case ($urandom_range(0, 6))
        0:       op = 6'b100011;
        1:       op = 6'b101011;
        2:       op = 6'b000000;
        3:       op = 6'b000100;
        4:       op = 6'b001000;
        5:       op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d pending expected=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
